// File: rtl/dmem_arbiter.sv
// Data-memory sequencer/arbiter between the MEM-stage CPU port and a DMA port, with a fixed access latency.
// Optional misaligned-access trap enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} grant_t;

  state_t      state, state_nxt;
  grant_t      grant;
  logic [3:0]  cnt;
  logic [3:0]  starve_cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        any_req;
  logic        pick_dma;
  logic [31:0] win_addr;
  logic        misalign;

  // Winner selection is only consumed while in IDLE.
  always_comb begin
    any_req  = cpu_req | dma_req;
    pick_dma = dma_req & (~cpu_req | (starve_cnt == 4'(STARVE_LIMIT)));
    win_addr = pick_dma ? dma_addr : cpu_addr;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    misalign = (win_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = misalign ? RESP : BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= GNT_CPU;
      cnt        <= '0;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      if (!dma_req)
        starve_cnt <= '0;
      else if (state == IDLE && any_req) begin
        if (pick_dma)                starve_cnt <= '0;
        else if (starve_cnt != '1)   starve_cnt <= starve_cnt + 4'd1;
      end

      case (state)
        IDLE: if (any_req) begin
          grant     <= pick_dma ? GNT_DMA : GNT_CPU;
          lat_we    <= pick_dma ? dma_we : cpu_we;
          lat_addr  <= win_addr;
          lat_wdata <= pick_dma ? dma_wdata : cpu_wdata;
          cnt       <= 4'(WAIT_CYCLES - 1);
          if (misalign) begin
            if (pick_dma) dma_rdata <= '0;
            else          cpu_rdata <= '0;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          else if (grant == GNT_DMA) dma_rdata <= lat_we ? '0 : mem_rdata;
          else                       cpu_rdata <= lat_we ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic align_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                align_q <= 1'b0;
    else if (state == IDLE && any_req && misalign) align_q <= 1'b1;
  end
  assign align_err = align_q;
`else
  assign align_err = 1'b0;
`endif

  // dmem side is driven purely from registered state.
  always_comb begin
    mem_read  = (state == BUSY) & ~lat_we;
    mem_write = (state == BUSY) &  lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    dma_ack   = (state == RESP) & (grant == GNT_DMA);
    cpu_stall = reset & cpu_req & ~((state == RESP) & (grant == GNT_CPU));
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=4) with a behavioural word-addressed dmem.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        align_err;

  logic [31:0] mem [0:63];
  logic        mem_init;

  int unsigned checks = 0;
  int unsigned errors = 0;

  dmem_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      mem[4]  <= 32'hDEADBEEF;
      mem[12] <= 32'hCAFEF00D;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic        e_stall, e_rd, e_wr;
    logic [31:0] e_addr;
    logic        e_ack;
    logic [31:0] e_crd, e_drd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic dr, logic [31:0] da,
                              logic st, logic rd, logic wr, logic [31:0] ad, logic ak,
                              logic [31:0] crd, logic [31:0] drd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = 1'b0; v.d_addr = da;
    v.e_stall = st; v.e_rd = rd; v.e_wr = wr; v.e_addr = ad; v.e_ack = ak;
    v.e_crd = crd; v.e_drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  logic [31:0] acc_q[$];
  logic        prev_busy;
  logic        dma_hold;
  int unsigned stall_n;

  initial begin
    // Reset with both requests asserted: everything must read zero.
    mem_init = 1'b1;
    reset    = 1'b0;
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_addr = 32'h30;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall",  32'(cpu_stall), 32'd0);
    chk("rst_rd",     32'(mem_read),  32'd0);
    chk("rst_wr",     32'(mem_write), 32'd0);
    chk("rst_addr",   mem_addr,       32'd0);
    chk("rst_wdata",  mem_wdata,      32'd0);
    chk("rst_ack",    32'(dma_ack),   32'd0);
    chk("rst_crd",    cpu_rdata,      32'd0);
    chk("rst_drd",    dma_rdata,      32'd0);
    chk("rst_align",  32'(align_err), 32'd0);
    @(negedge clk);
    mem_init = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rel_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    #1;
    chk("rel_cpu_rd",   32'(mem_read), 32'd1);
    chk("rel_cpu_addr", mem_addr,      32'h10);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Cycle-by-cycle table: CPU read, CPU write + readback, simultaneous CPU/DMA.
    tv.push_back(mk(1,0,32'h10,0, 0,0,  1,0,0,32'h10,0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h10,0, 0,0,  1,1,0,32'h10,0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h10,0, 0,0,  1,1,0,32'h10,0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h10,0, 0,0,  0,0,0,32'h10,0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(0,0,32'h0,0,  0,0,  0,0,0,32'h0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1,1,32'h20,32'h12345678, 0,0, 1,0,0,32'h0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1,1,32'h20,32'h12345678, 0,0, 1,0,1,32'h20,0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1,1,32'h20,32'h12345678, 0,0, 1,0,1,32'h20,0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(1,1,32'h20,32'h12345678, 0,0, 0,0,0,32'h0, 0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h20,0, 0,0,  1,0,0,32'h0, 0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h20,0, 0,0,  1,1,0,32'h20,0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h20,0, 0,0,  1,1,0,32'h20,0, 32'h0,        32'h0));
    tv.push_back(mk(1,0,32'h20,0, 0,0,  0,0,0,32'h0, 0, 32'h12345678, 32'h0));
    tv.push_back(mk(1,0,32'h10,0, 1,32'h30, 1,0,0,32'h0, 0, 32'h12345678, 32'h0));
    tv.push_back(mk(1,0,32'h10,0, 1,32'h30, 1,1,0,32'h10,0, 32'h12345678, 32'h0));
    tv.push_back(mk(1,0,32'h10,0, 1,32'h30, 1,1,0,32'h10,0, 32'h12345678, 32'h0));
    tv.push_back(mk(1,0,32'h10,0, 1,32'h30, 0,0,0,32'h0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(0,0,32'h0,0,  1,32'h30, 0,0,0,32'h0, 0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(0,0,32'h0,0,  1,32'h30, 0,1,0,32'h30,0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(0,0,32'h0,0,  1,32'h30, 0,1,0,32'h30,0, 32'hDEADBEEF, 32'h0));
    tv.push_back(mk(0,0,32'h0,0,  1,32'h30, 0,0,0,32'h0, 1, 32'hDEADBEEF, 32'hCAFEF00D));
    tv.push_back(mk(0,0,32'h0,0,  0,32'h0,  0,0,0,32'h0, 0, 32'hDEADBEEF, 32'hCAFEF00D));

    for (int i = 0; i < tv.size(); i++) begin
      cpu_req = tv[i].c_req; cpu_we = tv[i].c_we; cpu_addr = tv[i].c_addr; cpu_wdata = tv[i].c_wdata;
      dma_req = tv[i].d_req; dma_we = tv[i].d_we; dma_addr = tv[i].d_addr;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(tv[i].e_stall));
      chk($sformatf("v%0d_rd", i),    32'(mem_read),  32'(tv[i].e_rd));
      chk($sformatf("v%0d_wr", i),    32'(mem_write), 32'(tv[i].e_wr));
      chk($sformatf("v%0d_ack", i),   32'(dma_ack),   32'(tv[i].e_ack));
      chk($sformatf("v%0d_crd", i),   cpu_rdata,      tv[i].e_crd);
      chk($sformatf("v%0d_drd", i),   dma_rdata,      tv[i].e_drd);
      chk($sformatf("v%0d_align", i), 32'(align_err), 32'd0);
      if (tv[i].e_rd || tv[i].e_wr)
        chk($sformatf("v%0d_addr", i), mem_addr, tv[i].e_addr);
      if (tv[i].e_wr)
        chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].c_wdata);
      @(negedge clk);
    end

    // Starvation: CPU back-to-back with DMA pending -> 4 CPU, 1 DMA, CPU again.
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    dma_addr = 32'h30;
    dma_hold = 1'b1;
    prev_busy = 1'b0;
    for (int c = 0; c < 80 && acc_q.size() < 7; c++) begin
      dma_req = dma_hold;
      #1;
      if ((mem_read || mem_write) && !prev_busy) acc_q.push_back(mem_addr);
      prev_busy = mem_read | mem_write;
      if (dma_ack) dma_hold = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
    repeat (6) @(negedge clk);
    chk("starve_count", 32'(acc_q.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < acc_q.size())
        chk($sformatf("starve_acc%0d", k), acc_q[k], (k == 4) ? 32'h30 : 32'h10);
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    cpu_req = 1'b1; cpu_addr = 32'h13;
    #1;
    chk("al_stall0", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    #1;
    chk("al_rd",    32'(mem_read),  32'd0);
    chk("al_wr",    32'(mem_write), 32'd0);
    chk("al_stall", 32'(cpu_stall), 32'd0);
    chk("al_crd",   cpu_rdata,      32'd0);
    chk("al_err",   32'(align_err), 32'd1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
`endif

    // Reset in the middle of a write: strobe drops asynchronously, FSM restarts.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'hAAAA5555;
    @(negedge clk);
    #1;
    chk("mid_wr_busy", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_wr_drop", 32'(mem_write), 32'd0);
    chk("mid_stall",   32'(cpu_stall), 32'd0);
    chk("mid_crd",     cpu_rdata,      32'd0);
    chk("mid_align",   32'(align_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h10;
    stall_n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!cpu_stall) break;
      stall_n++;
      @(negedge clk);
    end
    chk("post_rst_stall_cycles", 32'(stall_n), 32'd3);
    chk("post_rst_crd",          cpu_rdata,     32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
